matrix_writeback: RTL and testbench
===================================

# matrix_writeback

Sequential writeback stage for the coprocessor's matrix datapath. Sits directly downstream of the combinational element-wise arithmetic units (add/subtract, 200-bit packed int8 result plus overflow flag). On a start pulse it captures the result, then streams the active elements of the N×N matrix to data memory one byte per transfer over a valid/ready write port. It reports completion and the latched overflow status to the control unit.

## Interface
- ADDR_WIDTH, 9, byte-address width of the memory write port
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; accepted only in IDLE
- base_addr  in  ADDR_WIDTH  destination address of element 0
- matrix_size  in  2  00=2×2 (4), 01=3×3 (9), 10=4×4 (16), 11=5×5 (25 elements)
- result_in  in  200  packed int8 elements; element j at bits [j*8 +: 8], row-major
- overflow_in  in  1  overflow flag from the arithmetic unit
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- status_overflow  out  1  overflow of last accepted operation
- mem_wr_en  out  1  write request (valid)
- mem_addr  out  ADDR_WIDTH  write byte address
- mem_wdata  out  8  write data
- mem_ready  in  1  memory accepts the write this cycle

## Operation
- States: IDLE, WRITE, DONE.
- IDLE: when start=1, capture result_in, overflow_in, base_addr, and N = count(matrix_size) into internal registers. Clear idx to 0. Go to WRITE. Inputs are don't-care after capture.
- WRITE: mem_wr_en=1, mem_addr = base + idx (mod 2^ADDR_WIDTH, wraps silently), mem_wdata = captured element idx.
- A transfer occurs when mem_wr_en & mem_ready. On a transfer, idx increments. On the transfer with idx = N−1, go to DONE.
- While mem_ready=0, mem_addr and mem_wdata hold stable; there is no timeout.
- DONE: done=1 for exactly one cycle. status_overflow ← captured overflow. Go to IDLE.
- Elements with index ≥ N are never written.
- start while busy=1 is ignored and has no side effects.
- status_overflow holds its value until the next DONE.
- Reset values: busy=0, done=0, status_overflow=0, mem_wr_en=0, mem_addr=0, mem_wdata=0. State=IDLE, idx=0.
- Reset asserted mid-operation: mem_wr_en drops immediately (asynchronously). No done pulse is produced, and the partial writes remain in memory.

## Timing
- start sampled at cycle 0 → mem_wr_en high from cycle 1.
- With mem_ready tied high, writes occupy cycles 1..N, done=1 in cycle N+1, and IDLE is reached in cycle N+2.
- Earliest next start is sampled in cycle N+2. Total occupancy is N+2 cycles per operation plus one cycle per mem_ready=0 stall.
- busy is high in cycles 1..N+1.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package coproc_pkg holds:
  - ELEM_WIDTH=8, MAX_ELEMS=25, MATRIX_BITS=200
  - size-code constants SIZE_2X2..SIZE_5X5
  - the state enum
- Sub-module matrix_elem_count: combinational size code → 5-bit active element count. It is shared with the arithmetic units so the count rule lives in one place.
- idx is 5 bits; the captured matrix is a 200-bit register indexed by idx.

## Test plan
- 2×2, base=0x010, elements 0x01,0xFF,0x7F,0x80, mem_ready=1 → 4 writes at 0x010..0x013 with those bytes on cycles 1–4. done in cycle 5, no write to 0x014.
- 5×5, elements j=j+1, overflow_in=1, mem_ready=1 → 25 sequential writes. done in cycle 26, status_overflow=1 after done and held until next done.
- 3×3 with mem_ready low for 3 cycles on element 4 → addr/data frozen during the stall, 9 writes total. done in cycle 13.
- base=0x1FE, 2×2 (ADDR_WIDTH=9) → addresses 0x1FE, 0x1FF, 0x000, 0x001.
- start pulsed again during WRITE with a different result_in → ignored; the original data is written, and the next start after IDLE is accepted normally.
- rst_n asserted mid-WRITE of a 4×4 → mem_wr_en=0 immediately, all outputs at reset values, no done. A subsequent start runs a full operation from idx 0.

Source files
------------

// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor matrix datapath: element geometry,
// matrix size codes and the writeback state encoding.
package coproc_pkg;

  localparam int ELEM_WIDTH  = 8;
  localparam int MAX_ELEMS   = 25;
  localparam int MATRIX_BITS = 200;
  localparam int IDX_WIDTH   = 5;

  localparam logic [1:0] SIZE_2X2 = 2'b00;
  localparam logic [1:0] SIZE_3X3 = 2'b01;
  localparam logic [1:0] SIZE_4X4 = 2'b10;
  localparam logic [1:0] SIZE_5X5 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/matrix_elem_count.sv
// Maps a matrix size code to its number of active elements (N*N); shared with
// the arithmetic units so the count rule has a single definition.
module matrix_elem_count
  import coproc_pkg::*;
(
  input  logic [1:0]           size_code,
  output logic [IDX_WIDTH-1:0] elem_count
);

  always_comb begin
    elem_count = 5'd4;
    case (size_code)
      SIZE_2X2: elem_count = 5'd4;
      SIZE_3X3: elem_count = 5'd9;
      SIZE_4X4: elem_count = 5'd16;
      SIZE_5X5: elem_count = 5'd25;
      default:  elem_count = 5'd4;
    endcase
  end

endmodule

// File: rtl/matrix_writeback.sv
// Writeback stage: captures a packed int8 matrix result on start and streams its
// active elements to memory one byte per valid/ready transfer, then pulses done.
module matrix_writeback
  import coproc_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  base_addr,
  input  logic [1:0]             matrix_size,
  input  logic [MATRIX_BITS-1:0] result_in,
  input  logic                   overflow_in,
  output logic                   busy,
  output logic                   done,
  output logic                   status_overflow,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [ELEM_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_ready
);

  wb_state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [MATRIX_BITS-1:0]  mat_q, mat_d;
  logic                    ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    stat_q, stat_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ELEM_WIDTH-1:0]   wdata_q, wdata_d;

  logic [IDX_WIDTH-1:0]    size_cnt;
  logic [IDX_WIDTH-1:0]    idx_nxt;
  logic                    last_elem;
  logic                    xfer;

  matrix_elem_count u_elem_count (
    .size_code  (matrix_size),
    .elem_count (size_cnt)
  );

  assign idx_nxt   = idx_q + 5'd1;
  assign last_elem = (idx_q == (cnt_q - 5'd1));
  assign xfer      = wr_en_q & mem_ready;

  // Address and data for the next element are precomputed so both outputs stay registered.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mat_d   = mat_q;
    ovf_d   = ovf_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    stat_d  = stat_q;
    wr_en_d = wr_en_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
          mat_d   = result_in;
          ovf_d   = overflow_in;
          base_d  = base_addr;
          cnt_d   = size_cnt;
          idx_d   = '0;
          busy_d  = 1'b1;
          wr_en_d = 1'b1;
          addr_d  = base_addr;
          wdata_d = result_in[ELEM_WIDTH-1:0];
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          if (last_elem) begin
            state_d = ST_DONE;
            wr_en_d = 1'b0;
            done_d  = 1'b1;
            stat_d  = ovf_q;
          end else begin
            idx_d   = idx_nxt;
            addr_d  = base_q + ADDR_WIDTH'(idx_nxt);
            wdata_d = mat_q[{idx_nxt, 3'b000} +: ELEM_WIDTH];
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        wr_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stat_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      stat_q  <= stat_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Captured operands are only read while WRITE is active, so they need no reset.
  always_ff @(posedge clk) begin
    mat_q  <= mat_d;
    ovf_q  <= ovf_d;
    base_q <= base_d;
    cnt_q  <= cnt_d;
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign status_overflow = stat_q;
  assign mem_wr_en       = wr_en_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;

endmodule

// File: tb/tb_matrix_writeback.sv
// Scenario bench for matrix_writeback: a scoreboard of expected (address, byte)
// beats is filled at start and drained by a write monitor.
module tb_matrix_writeback;
  import coproc_pkg::*;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [1:0]    matrix_size = '0;
  logic [199:0]  result_in = '0;
  logic          overflow_in = 1'b0;
  logic          mem_ready = 1'b0;
  logic          busy, done, status_overflow, mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  int tests = 0;
  int fails = 0;
  int writes = 0;
  logic [AW+7:0] sb_q[$];
  logic [AW+7:0] mon_exp;

  always #5 clk = ~clk;

  matrix_writeback #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .matrix_size     (matrix_size),
    .result_in       (result_in),
    .overflow_in     (overflow_in),
    .busy            (busy),
    .done            (done),
    .status_overflow (status_overflow),
    .mem_wr_en       (mem_wr_en),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_ready       (mem_ready)
  );

  // Every accepted write beat is checked against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (rst_n && mem_wr_en && mem_ready) begin
      writes++;
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_exp) begin
          fails++;
          $display("FAIL write_beat: addr/data=%h/%h, required %h/%h",
                   mem_addr, mem_wdata, mon_exp[AW+7:8], mon_exp[7:0]);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic launch(input logic [1:0] sz, input logic [AW-1:0] base,
                        input logic [199:0] data, input logic ovf);
    int n;
    n = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 9 : (sz == 2'd2) ? 16 : 25;
    @(negedge clk);
    start       = 1'b1;
    matrix_size = sz;
    base_addr   = base;
    result_in   = data;
    overflow_in = ovf;
    mem_ready   = 1'b1;
    writes      = 0;
    for (int j = 0; j < n; j++)
      sb_q.push_back({AW'((int'(base) + j) % (1 << AW)), data[j*8 +: 8]});
  endtask

  task automatic run_cycles(input int budget, output int first_wr, output int done_cyc,
                            output bit busy_ok);
    first_wr = -1;
    done_cyc = -1;
    busy_ok  = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (start) begin
        start       = 1'b0;
        result_in   = ~result_in;
        base_addr   = ~base_addr;
        overflow_in = ~overflow_in;
      end
      mem_ready = 1'b1;
      #1;
      if (mem_wr_en && first_wr < 0) first_wr = c;
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({busy, done, status_overflow, mem_wr_en, mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %b/%b/%b/%b/%h/%h, required all zero",
               busy, done, status_overflow, mem_wr_en, mem_addr, mem_wdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if ({busy, done, mem_wr_en} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: busy/done/wr_en=%b%b%b, required 000", busy, done, mem_wr_en);
    end
  endtask

  task automatic test_2x2();
    logic [199:0] d;
    int fw, dc;
    bit bok;
    d = {200{1'b1}} ^ {25{8'h55}};
    d[31:0] = 32'h807F_FF01;
    launch(SIZE_2X2, 9'h010, d, 1'b0);
    run_cycles(40, fw, dc, bok);
    tests++;
    if (fw !== 1) begin fails++; $display("FAIL 2x2_first_write: cycle %0d, required 1", fw); end
    tests++;
    if (dc !== 5) begin fails++; $display("FAIL 2x2_done_cycle: cycle %0d, required 5", dc); end
    tests++;
    if (!bok) begin fails++; $display("FAIL 2x2_busy: busy dropped before done, required high 1..5"); end
    tests++;
    if (writes !== 4 || sb_q.size() !== 0) begin
      fails++;
      $display("FAIL 2x2_write_count: writes=%0d left=%0d, required 4/0", writes, sb_q.size());
    end
    @(negedge clk);
    #1;
    tests++;
    if ({busy, done, mem_wr_en} !== 3'b000) begin
      fails++;
      $display("FAIL 2x2_idle: busy/done/wr_en=%b%b%b, required 000", busy, done, mem_wr_en);
    end
  endtask

  task automatic test_5x5_overflow();
    logic [199:0] d;
    int fw, dc;
    bit bok;
    for (int j = 0; j < 25; j++) d[j*8 +: 8] = 8'(j + 1);
    launch(SIZE_5X5, 9'h080, d, 1'b1);
    run_cycles(60, fw, dc, bok);
    tests++;
    if (dc !== 26) begin fails++; $display("FAIL 5x5_done_cycle: cycle %0d, required 26", dc); end
    tests++;
    if (writes !== 25 || sb_q.size() !== 0) begin
      fails++;
      $display("FAIL 5x5_write_count: writes=%0d left=%0d, required 25/0", writes, sb_q.size());
    end
    @(negedge clk);
    #1;
    tests++;
    if (status_overflow !== 1'b1) begin
      fails++;
      $display("FAIL 5x5_status: status_overflow=%b, required 1", status_overflow);
    end
  endtask

  task automatic test_status_hold();
    int fw, dc;
    bit bok;
    launch(SIZE_2X2, 9'h0A0, {25{8'h3C}}, 1'b0);
    run_cycles(3, fw, dc, bok);
    tests++;
    if (status_overflow !== 1'b1 || dc !== -1) begin
      fails++;
      $display("FAIL status_hold: status=%b done_cycle=%0d, required 1/-1", status_overflow, dc);
    end
    run_cycles(40, fw, dc, bok);
    tests++;
    if (dc !== 2) begin fails++; $display("FAIL status_hold_done: rel cycle %0d, required 2", dc); end
    @(negedge clk);
    #1;
    tests++;
    if (status_overflow !== 1'b0) begin
      fails++;
      $display("FAIL status_update: status_overflow=%b, required 0", status_overflow);
    end
  endtask

  task automatic test_stall();
    logic [199:0] d;
    int dc;
    for (int j = 0; j < 25; j++) d[j*8 +: 8] = 8'($urandom_range(0, 255));
    launch(SIZE_3X3, 9'h040, d, 1'b0);
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      mem_ready = !(c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 7) begin
        tests++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 9'h044 || mem_wdata !== d[39:32]) begin
          fails++;
          $display("FAIL stall_hold c%0d: en/addr/data=%b/%h/%h, required 1/044/%h",
                   c, mem_wr_en, mem_addr, mem_wdata, d[39:32]);
        end
      end
      if (done) begin
        dc = c;
        break;
      end
    end
    tests++;
    if (dc !== 13) begin fails++; $display("FAIL stall_done_cycle: cycle %0d, required 13", dc); end
    tests++;
    if (writes !== 9 || sb_q.size() !== 0) begin
      fails++;
      $display("FAIL stall_write_count: writes=%0d left=%0d, required 9/0", writes, sb_q.size());
    end
  endtask

  task automatic test_wrap();
    int fw, dc;
    bit bok;
    launch(SIZE_2X2, 9'h1FE, {25{8'hC3}} ^ 200'h0D_0C_0B_0A, 1'b0);
    run_cycles(40, fw, dc, bok);
    tests++;
    if (dc !== 5 || writes !== 4 || sb_q.size() !== 0) begin
      fails++;
      $display("FAIL wrap: done=%0d writes=%0d left=%0d, required 5/4/0", dc, writes, sb_q.size());
    end
  endtask

  task automatic test_start_ignored();
    logic [199:0] d;
    int dc, fw;
    bit bok;
    for (int j = 0; j < 25; j++) d[j*8 +: 8] = 8'(8'hA0 + j);
    launch(SIZE_3X3, 9'h100, d, 1'b0);
    dc = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 2);
      if (c == 2) begin
        result_in   = ~d;
        base_addr   = 9'h000;
        matrix_size = SIZE_5X5;
        overflow_in = 1'b1;
      end
      mem_ready = 1'b1;
      #1;
      if (done) begin
        dc = c;
        break;
      end
    end
    tests++;
    if (dc !== 10 || writes !== 9 || sb_q.size() !== 0) begin
      fails++;
      $display("FAIL start_ignored: done=%0d writes=%0d left=%0d, required 10/9/0",
               dc, writes, sb_q.size());
    end
    tests++;
    if (status_overflow !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored_status: status_overflow=%b, required 0", status_overflow);
    end
    // Back-to-back: the next start lands in the first IDLE cycle.
    launch(SIZE_2X2, 9'h150, {25{8'h5A}}, 1'b0);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle: busy=%b, required 0", busy); end
    run_cycles(40, fw, dc, bok);
    tests++;
    if (fw !== 1 || dc !== 5 || writes !== 4 || sb_q.size() !== 0) begin
      fails++;
      $display("FAIL b2b_run: first=%0d done=%0d writes=%0d left=%0d, required 1/5/4/0",
               fw, dc, writes, sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [199:0] d;
    int fw, dc;
    bit bok;
    bit saw_done;
    for (int j = 0; j < 25; j++) d[j*8 +: 8] = 8'(j * 7 + 3);
    launch(SIZE_4X4, 9'h020, d, 1'b1);
    run_cycles(6, fw, dc, bok);
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, status_overflow, mem_wr_en, mem_addr, mem_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %b/%b/%b/%b/%h/%h, required all zero",
               busy, done, status_overflow, mem_wr_en, mem_addr, mem_wdata);
    end
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1;
      if (done || busy) saw_done = 1'b1;
    end
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    if (done || busy) saw_done = 1'b1;
    tests++;
    if (saw_done) begin fails++; $display("FAIL reset_mid_no_done: done/busy seen=1, required 0"); end
    for (int j = 0; j < 25; j++) d[j*8 +: 8] = 8'(8'hF0 - j);
    launch(SIZE_4X4, 9'h030, d, 1'b0);
    run_cycles(40, fw, dc, bok);
    tests++;
    if (fw !== 1 || dc !== 17 || writes !== 16 || sb_q.size() !== 0) begin
      fails++;
      $display("FAIL reset_mid_rerun: first=%0d done=%0d writes=%0d left=%0d, required 1/17/16/0",
               fw, dc, writes, sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_2x2();
    test_5x5_overflow();
    test_status_hold();
    test_stall();
    test_wrap();
    test_start_ignored();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
